enc_param_reg: RTL and testbench
================================

// Module: enc_param_reg
// PURPOSE
//  Registered, parameterised priority encoder. It is the inverse of dec_param_enab: it turns a D-bit one-hot word back into a W-bit code plus an "any" flag.
//  The encode path is followed by a 2-entry output buffer with a valid/ready handshake on both sides, so it can sit between a stalling producer and consumer.
//  Used where decoded select lines must be re-encoded for storage or transport.
// PARAMETERS
//  W     3      code width; input width D = 2**W
//  ECW   8      width of the multi-hot error counter (saturating)
// PORTS
//  clk        in   1    rising-edge clock (the only clock)
//  rst_n      in   1    asynchronous, active-low reset
//  in_vld     in   1    in_d is valid this cycle
//  in_rdy     out  1    block can accept a word this cycle
//  in_d       in   D    decoded word to encode
//  out_vld    out  1    head of buffer holds a result
//  out_rdy    in   1    consumer takes the head this cycle
//  out_code   out  W    encoded index of the head entry
//  out_any    out  1    head entry had at least one bit set (the enable)
//  err_clr    in   1    clears err_multi and err_cnt
//  err_multi  out  1    sticky: a multi-hot word was accepted
//  err_cnt    out  ECW  number of multi-hot words accepted, saturating
// BEHAVIOUR
//  - Handshakes:
//    - Accept (push) occurs when in_vld & in_rdy.
//    - Pop occurs when out_vld & out_rdy.
//  - Encoding: the lowest set bit wins. code = index of that bit; any = |in_d.
//    - in_d == 0 gives code = 0 and any = 0. This zero word is still a valid entry and is pushed.
//  - Buffer: a 2-entry FIFO with count register cnt in 0..2.
//    - in_rdy = (cnt != 2), taken only from the registered cnt. There is no combinational path from out_rdy to in_rdy.
//    - out_vld = (cnt != 0). out_code and out_any come from the head entry and are registered.
//  - Latency: a word accepted at edge N is visible on out_* after edge N. That is 1 cycle when the buffer is empty.
//  - Count updates:
//    - push only:  cnt + 1
//    - pop only:   cnt - 1
//    - push + pop: cnt unchanged; order is preserved and the new word goes behind the remaining entry.
//      - With cnt == 1, the popped head is replaced by the new word.
//      - With cnt == 2 no push can occur (in_rdy = 0); the pop proceeds normally.
//  - out_code and out_any hold their value while out_vld & !out_rdy. Entries are never overwritten while stalled.
//  - Head contents when out_vld = 0 are don't-care; the implementation drives 0.
//  - Reset (rst_n = 0, any time, including mid-transfer) clears all buffered data:
//    - cnt = 0, in_rdy = 0 while rst_n = 0, out_vld = 0, out_code = 0, out_any = 0
//    - err_multi = 0, err_cnt = 0
//    - in_rdy rises in the first cycle after rst_n deasserts.
//  - Errors (feature on):
//    - An accepted word with more than one bit set sets err_multi and increments err_cnt, saturating at 2**ECW - 1.
//    - The word is still encoded using lowest-bit priority.
//    - err_clr takes precedence over a simultaneous error event: both outputs go to 0 on that edge.
// CONFIGURATION
//  ENC_ONEHOT_CHECK_EN defined:
//    - multi-hot detection, err_multi and err_cnt are present and operate as above.
//  ENC_ONEHOT_CHECK_EN undefined:
//    - the detection logic is removed; err_multi and err_cnt are tied to 0 and err_clr is ignored.
//    - The ports stay in the port list so the interface is unchanged.
// TESTING
//  - Reset: hold rst_n = 0 with in_vld = 1. Required: in_rdy = 0, out_vld = 0, out_code = 0, err_cnt = 0.
//    Release; in the next cycle in_rdy = 1.
//  - Sweep, W = 3, out_rdy = 1:
//    - in_d = 8'b0000_0001 .. 8'b1000_0000, one per cycle. Required: out_code = 0..7 with out_any = 1, each exactly 1 cycle after its push.
//    - Then in_d = 0. Required: out_code = 0, out_any = 0, out_vld = 1.
//  - Backpressure, out_rdy = 0:
//    - Push 8'h04 then 8'h40. Required: in_rdy = 0 after the 2nd push; out_code holds 2.
//    - Raise out_rdy. Required: out_code 2 then 6, in order; in_rdy returns to 1.
//  - Simultaneous push/pop at cnt = 1:
//    - Head = 8'h02; push 8'h80 with out_rdy = 1. Required: cnt stays 1, next out_code = 7.
//  - Multi-hot (feature on):
//    - Push 8'b0110_0000. Required: out_code = 5, err_multi = 1, err_cnt = 1.
//    - Force err_cnt to 255 and push another multi-hot word. Required: err_cnt stays 255.
//    - err_clr together with a multi-hot push. Required: err_multi = 0, err_cnt = 0.
//  - Mid-operation reset: with cnt = 2, pulse rst_n low for 3 ns between edges. Required: out_vld = 0 immediately (asynchronous), buffer empty afterwards.

Source files
------------

// File: rtl/enc_param_reg.sv
// enc_param_reg -- registered priority encoder behind a 2-entry valid/ready buffer.
//
// Turns a D-bit (D = 2**W) decoded word back into a W-bit index plus an "any"
// flag. The lowest set bit wins. An all-zero word encodes to code 0 / any 0
// and is still buffered as a normal entry.
//
// Optional feature macro: ENC_ONEHOT_CHECK_EN
//   defined   : multi-hot words raise sticky err_multi and bump a saturating
//               err_cnt; err_clr clears both and wins over a same-edge event.
//   undefined : err_multi / err_cnt are tied to 0 and err_clr is ignored.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_vld     in   1    in_d valid
//   in_rdy     out  1    buffer can take a word (registered state only)
//   in_d       in   D    decoded word
//   out_vld    out  1    head entry present
//   out_rdy    in   1    consumer takes the head
//   out_code   out  W    head entry index
//   out_any    out  1    head entry had a bit set
//   err_clr    in   1    clear error state
//   err_multi  out  1    sticky multi-hot flag
//   err_cnt    out  ECW  saturating multi-hot count
module enc_param_reg #(
    parameter int W   = 3,
    parameter int ECW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [(1<<W)-1:0]   in_d,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [W-1:0]        out_code,
    output logic                out_any,
    input  logic                err_clr,
    output logic                err_multi,
    output logic [ECW-1:0]      err_cnt
);

    localparam int D = 1 << W;

    // Entries hold {any, code}; e0 is always the head.
    logic [W:0] e0;
    logic [W:0] e1;
    logic [1:0] cnt;
    logic       live;   // low during reset and until the first edge after release
    logic       push;
    logic       pop;
    logic [W:0] enc;

    function automatic logic [W:0] encode(input logic [D-1:0] d);
        logic [W-1:0] c;
        c = '0;
        // Descending scan so the lowest set bit is the last to assign.
        for (int i = D - 1; i >= 0; i--) begin
            if (d[i]) c = W'(i);
        end
        return {|d, c};
    endfunction

    assign enc     = encode(in_d);
    assign in_rdy  = live & (cnt != 2'd2);
    assign out_vld = (cnt != 2'd0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    assign out_code = e0[W-1:0];
    assign out_any  = e0[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            live <= 1'b0;
            e0   <= '0;
            e1   <= '0;
        end else begin
            live <= 1'b1;
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= enc;
                    else             e1 <= enc;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // e1 is kept at zero whenever it is not occupied, so the
                    // head reads 0 once the buffer empties.
                    e0  <= e1;
                    e1  <= '0;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new word replaces the head.
                    e0 <= enc;
                end
                default: ;
            endcase
        end
    end

`ifdef ENC_ONEHOT_CHECK_EN
    logic multi;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(in_d & (in_d - D'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi <= 1'b0;
            err_cnt   <= '0;
        end else if (err_clr) begin
            err_multi <= 1'b0;
            err_cnt   <= '0;
        end else if (push && multi) begin
            err_multi <= 1'b1;
            if (err_cnt != {ECW{1'b1}}) err_cnt <= err_cnt + ECW'(1);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_multi      = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_enc_param_reg.sv
// tb_enc_param_reg -- scoreboard bench for enc_param_reg (W = 3, ECW = 8).
// Stimulus issues words and queues the expected {code, any}; a monitor on the
// falling edge compares the buffer head whenever out_vld is high and pops the
// queue when the consumer takes it. Error expectations follow the multi-hot
// rules when ENC_ONEHOT_CHECK_EN is defined and stay at zero otherwise.
module tb_enc_param_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_d;
    logic       out_vld;
    logic       out_rdy;
    logic [2:0] out_code;
    logic       out_any;
    logic       err_clr;
    logic       err_multi;
    logic [7:0] err_cnt;

    enc_param_reg #(.W(3), .ECW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_d(in_d),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_code(out_code), .out_any(out_any),
        .err_clr(err_clr), .err_multi(err_multi), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int q[$];           // expected entries: code + 16*any
    bit exp_multi = 0;
    int exp_cnt   = 0;
    bit mon_en    = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Lowest set index found by repeated halving.
    function automatic int low_idx(input int v);
        int idx = 0;
        if (v == 0) return 0;
        while (v % 2 == 0) begin
            v = v / 2;
            idx++;
        end
        return idx;
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input bit vld, input logic [7:0] d, input bit ordy, input bit clr);
        bit acc;
        bit nm;
        int nc;
        in_vld  = vld;
        in_d    = d;
        out_rdy = ordy;
        err_clr = clr;
        @(negedge clk);
        acc = vld && in_rdy;
        nm  = exp_multi;
        nc  = exp_cnt;
`ifdef ENC_ONEHOT_CHECK_EN
        if (clr) begin
            nm = 0;
            nc = 0;
        end else if (acc && $countones(d) > 1) begin
            nm = 1;
            if (nc < 255) nc++;
        end
`endif
        @(posedge clk);
        #1;
        if (acc) q.push_back(low_idx(int'(d)) + ((d != 0) ? 16 : 0));
        exp_multi = nm;
        exp_cnt   = nc;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("out_vld_vs_model", int'(out_vld), (q.size() != 0) ? 1 : 0);
            if (out_vld && q.size() != 0) begin
                check("head_code", int'(out_code), q[0] % 16);
                check("head_any", int'(out_any), q[0] / 16);
                if (out_rdy) void'(q.pop_front());
            end
            check("err_multi", int'(err_multi), int'(exp_multi));
            check("err_cnt", int'(err_cnt), exp_cnt);
        end
    end

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b1;
        in_d    = 8'h01;
        out_rdy = 1'b0;
        err_clr = 1'b0;

        // Reset with in_vld asserted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", int'(in_rdy), 0);
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_out_code", int'(out_code), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_rdy_before_edge", int'(in_rdy), 0);
        @(posedge clk);
        #1;
        check("rel_in_rdy", int'(in_rdy), 1);
        check("rel_out_vld", int'(out_vld), 0);
        in_vld = 1'b0;
        mon_en = 1'b1;

        // One-hot sweep, one per cycle, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(1 << i), 1, 0);
            check("sweep_vld", int'(out_vld), 1);
            check("sweep_code", int'(out_code), i);
            check("sweep_any", int'(out_any), 1);
        end
        step(1, 8'h00, 1, 0);
        check("zero_vld", int'(out_vld), 1);
        check("zero_code", int'(out_code), 0);
        check("zero_any", int'(out_any), 0);
        step(0, 8'h00, 1, 0);
        check("drained", int'(out_vld), 0);

        // Backpressure.
        step(1, 8'h04, 0, 0);
        step(1, 8'h40, 0, 0);
        check("bp_full_in_rdy", int'(in_rdy), 0);
        check("bp_hold_code", int'(out_code), 2);
        step(1, 8'h01, 0, 0);  // refused while full
        check("bp_still_code", int'(out_code), 2);
        step(0, 8'h00, 1, 0);
        check("bp_second_code", int'(out_code), 6);
        check("bp_in_rdy_back", int'(in_rdy), 1);
        step(0, 8'h00, 1, 0);
        check("bp_empty", int'(out_vld), 0);

        // Push and pop together with one entry.
        step(1, 8'h02, 0, 0);
        check("pp_head", int'(out_code), 1);
        step(1, 8'h80, 1, 0);
        check("pp_code", int'(out_code), 7);
        check("pp_in_rdy", int'(in_rdy), 1);
        step(0, 8'h00, 1, 0);
        check("pp_one_left", int'(out_vld), 0);

        // Multi-hot handling.
        step(1, 8'h60, 1, 0);
        check("mh_code", int'(out_code), 5);
        check("mh_err_multi", int'(err_multi), int'(exp_multi));
        check("mh_err_cnt", int'(err_cnt), exp_cnt);
        for (int i = 0; i < 258; i++) step(1, 8'hC3, 1, 0);
        check("mh_sat_cnt", int'(err_cnt), exp_cnt);
        check("mh_sat_code", int'(out_code), 0);
        step(1, 8'h0C, 1, 1);
        check("mh_clr_multi", int'(err_multi), int'(exp_multi));
        check("mh_clr_cnt", int'(err_cnt), exp_cnt);
        check("mh_clr_code", int'(out_code), 2);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            int r;
            r = $urandom_range(0, 3);
            if (r == 0)      d = 8'h00;
            else if (r == 3) d = 8'($urandom_range(0, 255));
            else             d = 8'(1 << $urandom_range(0, 7));
            step(bit'($urandom_range(0, 1)), d, bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 15) == 0));
        end

        // Fill, then an asynchronous reset pulse between edges.
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        step(1, 8'h10, 0, 0);
        step(1, 8'h60, 0, 0);
        check("mid_full", int'(in_rdy), 0);
        #5;
        rst_n = 1'b0;
        q.delete();
        exp_multi = 0;
        exp_cnt   = 0;
        #1;
        check("mid_out_vld_async", int'(out_vld), 0);
        check("mid_out_code_async", int'(out_code), 0);
        check("mid_in_rdy_async", int'(in_rdy), 0);
        check("mid_err_cnt_async", int'(err_cnt), 0);
        #2;
        rst_n = 1'b1;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        check("mid_in_rdy_after", int'(in_rdy), 1);
        check("mid_empty_after", int'(out_vld), 0);
        step(1, 8'h20, 1, 0);
        check("mid_resume_code", int'(out_code), 5);
        step(0, 8'h00, 1, 0);
        check("mid_resume_empty", int'(out_vld), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
